// File: rtl/cacc_dbuf_pkg.sv
// Shared constants and types for the CACC delivery-buffer read controller.
// Pointer widths, buffer depth and the layer state encoding live here.
package cacc_dbuf_pkg;
  localparam int DBUF_AWIDTH = 6;
  localparam int DEPTH       = 2 ** DBUF_AWIDTH;
  localparam int OCC_WIDTH   = DBUF_AWIDTH + 1;
  localparam int LCNT_WIDTH  = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;
endpackage

// File: rtl/cacc_dbuf_wrap_ptr.sv
// Wrapping RAM pointer with increment enable and synchronous clear.
// Depth is a power of two, so wrap is the natural modulo overflow.
module cacc_dbuf_wrap_ptr #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/cacc_dbuf_rd_ctrl.sv
// Delivery-buffer read controller: allocates write slots, tracks occupancy
// and issues one read per entry with a last-of-layer flag.
module cacc_dbuf_rd_ctrl
  import cacc_dbuf_pkg::*;
(
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   dbuf_wr_en,
  output logic [DBUF_AWIDTH-1:0] dbuf_wr_addr,
  output logic                   dbuf_wr_ready,
  input  logic                   layer_start,
  input  logic [LCNT_WIDTH-1:0]  cfg_layer_entries,
  input  logic                   dbuf_rd_ready,
  output logic                   dbuf_rd_en,
  output logic [DBUF_AWIDTH-1:0] dbuf_rd_addr,
  output logic                   dbuf_rd_layer_end,
  output logic                   layer_busy,
  output logic [OCC_WIDTH-1:0]   dbuf_occupancy
);

  state_e                state_q, state_d;
  logic [OCC_WIDTH-1:0]  occ_q, occ_d;
  logic [LCNT_WIDTH-1:0] rem_q, rem_d;
  logic [LCNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                  wr_accept;
  logic                  clr;

  assign clr = ~nvdla_core_rstn;

  // Ready comes from registered occupancy, so a full buffer stays
  // closed for the cycle its first read is issued.
  assign dbuf_wr_ready = (occ_q != OCC_WIDTH'(DEPTH));
  assign wr_accept     = dbuf_wr_en & dbuf_wr_ready;

  assign dbuf_rd_en = (state_q == ACTIVE) & (occ_q != '0)
                    & dbuf_rd_ready;
  assign dbuf_rd_layer_end = dbuf_rd_en
                           & (rem_q == LCNT_WIDTH'(1));

  assign layer_busy     = (state_q == ACTIVE);
  assign dbuf_occupancy = occ_q;

  cacc_dbuf_wrap_ptr #(.W(DBUF_AWIDTH)) u_wr_ptr (
    .clk (nvdla_core_clk),
    .clr (clr),
    .inc (wr_accept),
    .ptr (dbuf_wr_addr)
  );

  cacc_dbuf_wrap_ptr #(.W(DBUF_AWIDTH)) u_rd_ptr (
    .clk (nvdla_core_clk),
    .clr (clr),
    .inc (dbuf_rd_en),
    .ptr (dbuf_rd_addr)
  );

  always_comb begin
    occ_d = occ_q + OCC_WIDTH'(wr_accept)
          - OCC_WIDTH'(dbuf_rd_en);
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    rd_cnt_d = rd_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (layer_start && (cfg_layer_entries != '0)) begin
          state_d  = ACTIVE;
          rem_d    = cfg_layer_entries;
          rd_cnt_d = '0;
        end
      end
      ACTIVE: begin
        if (dbuf_rd_en) begin
          rem_d    = rem_q - LCNT_WIDTH'(1);
          rd_cnt_d = rd_cnt_q + LCNT_WIDTH'(1);
          if (rem_q == LCNT_WIDTH'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q  <= IDLE;
      occ_q    <= '0;
      rem_q    <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      occ_q    <= occ_d;
      rem_q    <= rem_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

endmodule

// File: tb/tb_cacc_dbuf_rd_ctrl.sv
// Directed self-checking bench for cacc_dbuf_rd_ctrl.
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_cacc_dbuf_rd_ctrl;

  logic        clk;
  logic        rstn;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic        wr_ready;
  logic        lstart;
  logic [15:0] cfg;
  logic        rd_ready;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic        rd_end;
  logic        busy;
  logic [6:0]  occ;

  int errors = 0;
  int checks = 0;

  cacc_dbuf_rd_ctrl dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rstn),
    .dbuf_wr_en        (wr_en),
    .dbuf_wr_addr      (wr_addr),
    .dbuf_wr_ready     (wr_ready),
    .layer_start       (lstart),
    .cfg_layer_entries (cfg),
    .dbuf_rd_ready     (rd_ready),
    .dbuf_rd_en        (rd_en),
    .dbuf_rd_addr      (rd_addr),
    .dbuf_rd_layer_end (rd_end),
    .layer_busy        (busy),
    .dbuf_occupancy    (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_n(input int n);
    wr_en = 1'b1;
    repeat (n) tick();
    wr_en = 1'b0;
  endtask

  task automatic start_layer(input logic [15:0] n);
    lstart = 1'b1;
    cfg    = n;
    tick();
    lstart = 1'b0;
    cfg    = 16'd0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    checks++;
    if ({wr_addr, rd_addr, occ} !== 19'd0) begin
      errors++;
      $display("FAIL reset_ptrs got wr=%0d rd=%0d occ=%0d exp 0/0/0",
               wr_addr, rd_addr, occ);
    end
    checks++;
    if ({rd_en, rd_end, wr_ready, busy} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_flags got rd_en=%b end=%b rdy=%b busy=%b exp 0 0 1 0",
               rd_en, rd_end, wr_ready, busy);
    end
  endtask

  task automatic test_basic();
    wr_n(3);
    checks++;
    if (wr_addr !== 6'd3 || occ !== 7'd3) begin
      errors++;
      $display("FAIL basic_wr got wr=%0d occ=%0d exp 3/3", wr_addr, occ);
    end
    start_layer(16'd3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b exp 1", busy);
    end
    for (int i = 0; i < 3; i++) begin
      rd_ready = 1'b1;
      #1;
      checks++;
      if (rd_en !== 1'b1 || rd_addr !== 6'(i) || rd_end !== (i == 2)) begin
        errors++;
        $display("FAIL basic_rd i=%0d got en=%b addr=%0d end=%b exp 1 %0d %b",
                 i, rd_en, rd_addr, rd_end, i, (i == 2));
      end
      tick();
      rd_ready = 1'b0;
      #1;
      checks++;
      if (rd_en !== 1'b0 || busy !== (i != 2)) begin
        errors++;
        $display("FAIL basic_gap i=%0d got en=%b busy=%b exp 0 %b",
                 i, rd_en, busy, (i != 2));
      end
      tick();
    end
    checks++;
    if (occ !== 7'd0 || rd_addr !== 6'd3) begin
      errors++;
      $display("FAIL basic_end got occ=%0d rd=%0d exp 0/3", occ, rd_addr);
    end
  endtask

  task automatic test_full();
    int bad = 0;
    int ends = 0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    wr_n(64);
    checks++;
    if (wr_ready !== 1'b0 || occ !== 7'd64 || wr_addr !== 6'd0) begin
      errors++;
      $display("FAIL full_state got rdy=%b occ=%0d wr=%0d exp 0/64/0",
               wr_ready, occ, wr_addr);
    end
    wr_n(1);
    checks++;
    if (wr_addr !== 6'd0 || occ !== 7'd64) begin
      errors++;
      $display("FAIL full_drop got wr=%0d occ=%0d exp 0/64", wr_addr, occ);
    end
    start_layer(16'd64);
    wr_en    = 1'b1;
    rd_ready = 1'b1;
    #1;
    checks++;
    if (rd_en !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_rdwr got en=%b rdy=%b exp 1/0", rd_en, wr_ready);
    end
    tick();
    wr_en = 1'b0;
    checks++;
    if (occ !== 7'd63 || wr_ready !== 1'b1 || wr_addr !== 6'd0) begin
      errors++;
      $display("FAIL full_resume got occ=%0d rdy=%b wr=%0d exp 63/1/0",
               occ, wr_ready, wr_addr);
    end
    for (int i = 1; i < 64; i++) begin
      if (rd_en !== 1'b1 || rd_addr !== 6'(i)) bad++;
      if (rd_end === 1'b1) ends += (i == 63) ? 1 : 100;
      tick();
    end
    rd_ready = 1'b0;
    checks++;
    if (bad != 0 || ends != 1) begin
      errors++;
      $display("FAIL full_drain got bad=%0d ends=%0d exp 0/1", bad, ends);
    end
    checks++;
    if (busy !== 1'b0 || occ !== 7'd0 || rd_addr !== 6'd0) begin
      errors++;
      $display("FAIL full_idle got busy=%b occ=%0d rd=%0d exp 0/0/0",
               busy, occ, rd_addr);
    end
  endtask

  task automatic test_wrap();
    wr_n(60);
    start_layer(16'd60);
    rd_ready = 1'b1;
    repeat (60) tick();
    rd_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || rd_addr !== 6'd60 || wr_addr !== 6'd60) begin
      errors++;
      $display("FAIL wrap_pre got busy=%b rd=%0d wr=%0d exp 0/60/60",
               busy, rd_addr, wr_addr);
    end
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1;
      checks++;
      if (wr_addr !== 6'((60 + i) % 64)) begin
        errors++;
        $display("FAIL wrap_wr i=%0d got %0d exp %0d",
                 i, wr_addr, (60 + i) % 64);
      end
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (occ !== 7'd10 || wr_addr !== 6'd6) begin
      errors++;
      $display("FAIL wrap_occ got occ=%0d wr=%0d exp 10/6", occ, wr_addr);
    end
    start_layer(16'd10);
    for (int i = 0; i < 10; i++) begin
      rd_ready = 1'b1;
      #1;
      checks++;
      if (rd_en !== 1'b1 || rd_addr !== 6'((60 + i) % 64)
          || rd_end !== (i == 9)) begin
        errors++;
        $display("FAIL wrap_rd i=%0d got en=%b addr=%0d end=%b exp 1 %0d %b",
                 i, rd_en, rd_addr, rd_end, (60 + i) % 64, (i == 9));
      end
      tick();
      rd_ready = 1'b0;
      tick();
    end
    checks++;
    if (busy !== 1'b0 || occ !== 7'd0) begin
      errors++;
      $display("FAIL wrap_end got busy=%b occ=%0d exp 0/0", busy, occ);
    end
  endtask

  task automatic test_simul_and_ignore();
    int ends_at = -1;
    wr_n(5);
    start_layer(16'd6);
    wr_en    = 1'b1;
    rd_ready = 1'b1;
    #1;
    checks++;
    if (occ !== 7'd5 || rd_en !== 1'b1) begin
      errors++;
      $display("FAIL simul_pre got occ=%0d en=%b exp 5/1", occ, rd_en);
    end
    tick();
    wr_en    = 1'b0;
    rd_ready = 1'b0;
    checks++;
    if (occ !== 7'd5 || wr_addr !== 6'd12 || rd_addr !== 6'd7) begin
      errors++;
      $display("FAIL simul_occ got occ=%0d wr=%0d rd=%0d exp 5/12/7",
               occ, wr_addr, rd_addr);
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (rd_en !== 1'b0 || rd_addr !== 6'd7) begin
        errors++;
        $display("FAIL stall i=%0d got en=%b rd=%0d exp 0/7",
                 i, rd_en, rd_addr);
      end
      tick();
    end
    start_layer(16'd2);
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (rd_end === 1'b1 && ends_at < 0) ends_at = i;
      tick();
    end
    rd_ready = 1'b0;
    checks++;
    if (ends_at != 4 || busy !== 1'b0 || rd_addr !== 6'd12) begin
      errors++;
      $display("FAIL ignore_start got end_at=%0d busy=%b rd=%0d exp 4/0/12",
               ends_at, busy, rd_addr);
    end
  endtask

  task automatic test_zero_layer();
    wr_n(1);
    start_layer(16'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0 || occ !== 7'd1) begin
        errors++;
        $display("FAIL zero_layer i=%0d got busy=%b en=%b occ=%0d exp 0/0/1",
                 i, busy, rd_en, occ);
      end
      tick();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr_n(6);
    start_layer(16'd20);
    checks++;
    if (occ !== 7'd7 || busy !== 1'b1 || wr_addr !== 6'd19) begin
      errors++;
      $display("FAIL mid_pre got occ=%0d busy=%b wr=%0d exp 7/1/19",
               occ, busy, wr_addr);
    end
    rd_ready = 1'b1;
    rstn     = 1'b0;
    tick();
    rd_ready = 1'b0;
    #1;
    checks++;
    if ({wr_addr, rd_addr, occ} !== 19'd0 || busy !== 1'b0
        || rd_en !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got wr=%0d rd=%0d occ=%0d busy=%b en=%b rdy=%b",
               wr_addr, rd_addr, occ, busy, rd_en, wr_ready);
    end
    rstn = 1'b1;
    tick();
  endtask

  initial begin
    rstn     = 1'b0;
    wr_en    = 1'b0;
    lstart   = 1'b0;
    cfg      = 16'd0;
    rd_ready = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_simul_and_ignore();
    test_zero_layer();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cacc_dbuf_rd_ctrl.md
Name: cacc_dbuf_rd_ctrl

Overview:
Read-side controller that sits directly upstream of the CACC delivery buffer. It allocates write addresses for the assembly stage and tracks the occupancy of committed entries. It issues one buffer read per entry whenever the delivery buffer reports ready, and flags the final read of each layer so the delivery buffer can generate the SDP layer_end marker and the done interrupt.

Parameters:
DBUF_AWIDTH, 6, address width of the delivery buffer RAM; DEPTH = 2**DBUF_AWIDTH (64).
LCNT_WIDTH, 16, width of the per-layer entry count.

Ports:
nvdla_core_clk  in  1  core clock; all logic is on the rising edge.
nvdla_core_rstn  in  1  reset, synchronous and active-low.
dbuf_wr_en  in  1  assembly stage commits one entry at dbuf_wr_addr this cycle.
dbuf_wr_addr  out  DBUF_AWIDTH  current write pointer (registered).
dbuf_wr_ready  out  1  buffer not full; a write is accepted only when this is high.
layer_start  in  1  single-cycle pulse that starts a layer.
cfg_layer_entries  in  LCNT_WIDTH  number of entries in the layer; sampled on layer_start.
dbuf_rd_ready  in  1  delivery buffer can accept a read (no SDP beats left).
dbuf_rd_en  out  1  read request to the delivery buffer.
dbuf_rd_addr  out  DBUF_AWIDTH  read pointer (registered).
dbuf_rd_layer_end  out  1  qualifies dbuf_rd_en; the current read is the last entry of the layer.
layer_busy  out  1  high while a layer is in ACTIVE state.
dbuf_occupancy  out  DBUF_AWIDTH+1  committed and unread entry count.

Behaviour:
- Reset (synchronous, low on a rising edge):
  - wr_ptr, rd_ptr, occupancy, read count and remaining-entry count clear to 0; state goes to IDLE.
  - Outputs after reset: dbuf_rd_en=0, dbuf_rd_layer_end=0, dbuf_wr_ready=1, layer_busy=0, both addresses 0.
  - A reset mid-layer abandons that layer; buffered entries are discarded.
- Write side:
  - wr_accept = dbuf_wr_en & dbuf_wr_ready.
  - wr_ptr increments on wr_accept and wraps from DEPTH-1 to 0.
  - dbuf_wr_ready = (occupancy != DEPTH), computed combinationally from the registered occupancy.
  - dbuf_wr_en while not ready is dropped: no pointer advance, no occupancy change.
  - Writes are accepted in any state, so the next layer may prefill while IDLE.
- State machine:
  - IDLE: on layer_start with cfg_layer_entries != 0, latch the count into remaining, clear the read count, go to ACTIVE.
  - IDLE: layer_start with a count of 0 is ignored and the block stays IDLE.
  - ACTIVE: layer_start is ignored. On a read where remaining == 1, return to IDLE the next cycle.
  - layer_busy is high exactly in ACTIVE.
- Read issue (combinational from registered state):
  - dbuf_rd_en = (state==ACTIVE) & (occupancy != 0) & dbuf_rd_ready.
  - dbuf_rd_layer_end = dbuf_rd_en & (remaining == 1).
  - On dbuf_rd_en: rd_ptr increments with wrap, remaining decrements.
- Back-to-back reads: the delivery buffer drops dbuf_rd_ready the cycle after a read. The next read therefore waits for ready to return, and the block never relies on holding rd_en.
- Occupancy update:
  - occupancy_next = occupancy + wr_accept - dbuf_rd_en.
  - Simultaneous write and read leave it unchanged.
- Latency: an entry written at cycle t is readable at t+1 at the earliest. An entry is freed when its read is issued, because the RAM output holds the data while it drains.
- Pointers are never reset between layers; wrap is continuous across layers.
- Full plus simultaneous read: wr_ready is still 0 that cycle, since it is based on registered occupancy. Writing resumes the next cycle.

Decomposition:
- Shared package cacc_dbuf_pkg:
  - DBUF_AWIDTH and DEPTH constants.
  - State enum {IDLE, ACTIVE}.
  - Occupancy width constant.
- Natural sub-module: cacc_dbuf_wrap_ptr, a wrapping pointer with inc enable and sync clear. It is instantiated twice, for the write and read pointers.

Test Plan:
- Reset, then 3 writes, then layer_start with entries=3 and rd_ready held 1 -> reads at addresses 0,1,2 spaced by rd_ready. layer_end only on addr 2. layer_busy falls the cycle after. Occupancy ends at 0.
- 64 writes with no layer -> wr_ready=0 at occupancy 64; a 65th wr_en is dropped and wr_ptr stays 0. layer_start entries=64 -> first read restores wr_ready the next cycle.
- Pointer wrap: 60 writes/reads, then a 10-entry layer -> addresses 60..63,0..5 in order for both writes and reads. layer_end on addr 5.
- Simultaneous wr_accept and rd_en at occupancy 5 -> occupancy stays 5; rd_ready low for 4 cycles stalls reads with no address change.
- layer_start with entries=0 -> stays IDLE, no rd_en. layer_start during ACTIVE is ignored: the current layer count is unchanged and layer_end still comes at the original last entry.
- Reset asserted mid-layer with occupancy 7 -> next cycle all pointers and occupancy are 0, IDLE, rd_en=0, wr_ready=1.
